// File: rtl/imem_fetch_resp.sv
// Instruction-memory responder: answers fetch requests from a word-addressed
// store after a fixed pipeline latency, flagging misaligned/out-of-range fetches.
module imem_fetch_resp #(
   parameter int                ADDR_W      = 64,
   parameter int                DEPTH_WORDS = 4096,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int                LATENCY     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic              inst_ena,
   output logic [31:0]       inst,
   output logic              inst_valid,
   output logic              inst_fault,
   output logic [ADDR_W-1:0] resp_addr,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [31:0]       ld_data
);

   localparam int                IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH_WORDS) << 2;
   localparam logic [31:0]       NOP   = 32'h00000013;

   if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("imem_fetch_resp: LATENCY must be 1..4");
   end

   logic [31:0]       store [DEPTH_WORDS];

   logic [ADDR_W-1:0] req_off;
   logic [ADDR_W-1:0] ld_off;
   logic              req_fault;
   logic              ld_fault;
   logic [IDX_W-1:0]  req_idx;
   logic [IDX_W-1:0]  ld_idx;
   logic              ld_hit;
   logic [31:0]       rd_data;

   logic              pipe_valid [LATENCY];
   logic              pipe_fault [LATENCY];
   logic [ADDR_W-1:0] pipe_addr  [LATENCY];
   logic [31:0]       pipe_data  [LATENCY];

   // The explicit below-base test keeps addresses under BASE_ADDR from
   // wrapping around into the top of the store.
   always_comb begin
      req_off   = inst_addr - BASE_ADDR;
      req_fault = (inst_addr[1:0] != 2'b00) || (inst_addr < BASE_ADDR) || (req_off >= SPAN);
      req_idx   = req_off[IDX_W+1:2];

      ld_off    = ld_addr - BASE_ADDR;
      ld_fault  = (ld_addr[1:0] != 2'b00) || (ld_addr < BASE_ADDR) || (ld_off >= SPAN);
      ld_idx    = ld_off[IDX_W+1:2];

      ld_hit    = ld_en && !ld_fault && (ld_idx == req_idx);

      rd_data   = NOP;
      if (!req_fault) begin
         rd_data = ld_hit ? ld_data : store[req_idx];
      end
   end

   // Store contents survive reset so a preload is not lost across it.
   always_ff @(posedge clk) begin
      if (ld_en && !ld_fault) begin
         store[ld_idx] <= ld_data;
      end
   end

   // Every stage forwards its payload only alongside a valid bit, so the last
   // stage naturally holds the previous response through idle slots.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < LATENCY; k++) begin
            pipe_valid[k] <= 1'b0;
            pipe_fault[k] <= 1'b0;
            pipe_addr[k]  <= '0;
            pipe_data[k]  <= NOP;
         end
      end else begin
         pipe_valid[0] <= inst_ena;
         if (inst_ena) begin
            pipe_fault[0] <= req_fault;
            pipe_addr[0]  <= inst_addr;
            pipe_data[0]  <= rd_data;
         end
         for (int k = 1; k < LATENCY; k++) begin
            pipe_valid[k] <= pipe_valid[k-1];
            if (pipe_valid[k-1]) begin
               pipe_fault[k] <= pipe_fault[k-1];
               pipe_addr[k]  <= pipe_addr[k-1];
               pipe_data[k]  <= pipe_data[k-1];
            end
         end
      end
   end

   assign inst       = pipe_data[LATENCY-1];
   assign inst_valid = pipe_valid[LATENCY-1];
   assign inst_fault = pipe_fault[LATENCY-1];
   assign resp_addr  = pipe_addr[LATENCY-1];

endmodule

// File: tb/tb_imem_fetch_resp.sv
// Directed bench for imem_fetch_resp: four instances cover latency 1/3/4 and a
// non-zero base address, all checked against hand-computed responses.
module tb_imem_fetch_resp;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic [63:0] inst_addr = '0;
   logic        inst_ena  = 1'b0;
   logic        ld_en     = 1'b0;
   logic [63:0] ld_addr   = '0;
   logic [31:0] ld_data   = '0;

   logic [63:0] d_inst_addr = '0;
   logic        d_inst_ena  = 1'b0;
   logic        d_ld_en     = 1'b0;
   logic [63:0] d_ld_addr   = '0;
   logic [31:0] d_ld_data   = '0;

   logic [31:0] a_inst, b_inst, c_inst, d_inst;
   logic        a_valid, b_valid, c_valid, d_valid;
   logic        a_fault, b_fault, c_fault, d_fault;
   logic [63:0] a_resp, b_resp, c_resp, d_resp;

   int checks   = 0;
   int failures = 0;

   logic [31:0] words [4];
   logic        b_exp_valid [7];
   logic [31:0] b_exp_inst  [7];

   always #5 clk = ~clk;

   imem_fetch_resp u_a (
      .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_ena(inst_ena),
      .inst(a_inst), .inst_valid(a_valid), .inst_fault(a_fault), .resp_addr(a_resp),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   imem_fetch_resp #(.LATENCY(3)) u_b (
      .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_ena(inst_ena),
      .inst(b_inst), .inst_valid(b_valid), .inst_fault(b_fault), .resp_addr(b_resp),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   imem_fetch_resp #(.LATENCY(4)) u_c (
      .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_ena(inst_ena),
      .inst(c_inst), .inst_valid(c_valid), .inst_fault(c_fault), .resp_addr(c_resp),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   imem_fetch_resp #(.BASE_ADDR(64'h8000_0000)) u_d (
      .clk(clk), .rst(rst), .inst_addr(d_inst_addr), .inst_ena(d_inst_ena),
      .inst(d_inst), .inst_valid(d_valid), .inst_fault(d_fault), .resp_addr(d_resp),
      .ld_en(d_ld_en), .ld_addr(d_ld_addr), .ld_data(d_ld_data)
   );

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one edge's worth of shared-bus inputs, then advance past that edge.
   task automatic applyStimulus(input logic ena, input logic [63:0] addr,
                                input logic lden, input logic [63:0] ldaddr,
                                input logic [31:0] lddata);
      inst_ena  = ena;
      inst_addr = addr;
      ld_en     = lden;
      ld_addr   = ldaddr;
      ld_data   = lddata;
      tick();
   endtask

   initial begin
      words[0] = 32'h00100093;
      words[1] = 32'h00200113;
      words[2] = 32'h002081B3;
      words[3] = 32'h00000073;

      #12;
      checkOutput("reset_valid", {63'd0, a_valid}, 64'd0);
      checkOutput("reset_fault", {63'd0, a_fault}, 64'd0);
      checkOutput("reset_inst",  {32'd0, a_inst}, {32'd0, NOP});
      checkOutput("reset_addr",  a_resp, 64'd0);
      rst = 1'b1;

      // Preload, including the last word and word 4 ahead of the bypass test
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 64'd0, 1'b1, 64'(4 * i), words[i]);
      applyStimulus(1'b0, 64'd0, 1'b1, 64'h3FFC, 32'hCAFEF00D);
      applyStimulus(1'b0, 64'd0, 1'b1, 64'h10, 32'h11111111);
      applyStimulus(1'b0, 64'd0, 1'b0, 64'd0, 32'd0);
      d_ld_en   = 1'b1;
      d_ld_addr = 64'h8000_0000;
      d_ld_data = 32'hABCD0001;
      tick();
      d_ld_en = 1'b0;

      #3 rst = 1'b0;
      #2 rst = 1'b1;
      tick();

      // Back-to-back fetches on latency 1
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 64'(4 * i), 1'b0, 64'd0, 32'd0);
         checkOutput($sformatf("b2b_valid%0d", i), {63'd0, a_valid}, 64'd1);
         checkOutput($sformatf("b2b_inst%0d", i), {32'd0, a_inst}, {32'd0, words[i]});
         checkOutput($sformatf("b2b_addr%0d", i), a_resp, 64'(4 * i));
         checkOutput($sformatf("b2b_fault%0d", i), {63'd0, a_fault}, 64'd0);
      end
      applyStimulus(1'b0, 64'h40, 1'b0, 64'd0, 32'd0);
      checkOutput("idle_valid", {63'd0, a_valid}, 64'd0);
      checkOutput("idle_inst_hold", {32'd0, a_inst}, {32'd0, words[3]});
      checkOutput("idle_addr_hold", a_resp, 64'hC);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 64'd0, 1'b0, 64'd0, 32'd0);

      // Latency 3 with gapped pattern 1,0,1,1
      b_exp_valid = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      b_exp_inst  = '{words[3], words[3], words[0], words[0], words[2], words[3], words[3]};
      for (int t = 0; t < 7; t++) begin
         case (t)
            0:       applyStimulus(1'b1, 64'h0, 1'b0, 64'd0, 32'd0);
            1:       applyStimulus(1'b0, 64'h4, 1'b0, 64'd0, 32'd0);
            2:       applyStimulus(1'b1, 64'h8, 1'b0, 64'd0, 32'd0);
            3:       applyStimulus(1'b1, 64'hC, 1'b0, 64'd0, 32'd0);
            default: applyStimulus(1'b0, 64'h0, 1'b0, 64'd0, 32'd0);
         endcase
         checkOutput($sformatf("lat3_valid%0d", t), {63'd0, b_valid}, {63'd0, b_exp_valid[t]});
         checkOutput($sformatf("lat3_inst%0d", t), {32'd0, b_inst}, {32'd0, b_exp_inst[t]});
      end

      // Fault decode on latency 1
      applyStimulus(1'b1, 64'h2, 1'b0, 64'd0, 32'd0);
      checkOutput("misalign_fault", {63'd0, a_fault}, 64'd1);
      checkOutput("misalign_inst", {32'd0, a_inst}, {32'd0, NOP});
      checkOutput("misalign_addr", a_resp, 64'h2);
      applyStimulus(1'b1, 64'h4000, 1'b0, 64'd0, 32'd0);
      checkOutput("oor_fault", {63'd0, a_fault}, 64'd1);
      checkOutput("oor_inst", {32'd0, a_inst}, {32'd0, NOP});
      checkOutput("oor_addr", a_resp, 64'h4000);
      applyStimulus(1'b1, 64'h3FFC, 1'b0, 64'd0, 32'd0);
      checkOutput("last_fault", {63'd0, a_fault}, 64'd0);
      checkOutput("last_inst", {32'd0, a_inst}, {32'd0, 32'hCAFEF00D});

      // Same-edge load and fetch, then an ignored misaligned load
      applyStimulus(1'b1, 64'h10, 1'b1, 64'h10, 32'hDEADBEEF);
      checkOutput("bypass_inst", {32'd0, a_inst}, {32'd0, 32'hDEADBEEF});
      applyStimulus(1'b0, 64'h0, 1'b1, 64'h11, 32'h12345678);
      applyStimulus(1'b1, 64'h10, 1'b0, 64'd0, 32'd0);
      checkOutput("misld_inst", {32'd0, a_inst}, {32'd0, 32'hDEADBEEF});
      checkOutput("misld_fault", {63'd0, a_fault}, 64'd0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 64'd0, 1'b0, 64'd0, 32'd0);

      // Latency 4, reset while responses are in flight
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 64'(4 * i), 1'b0, 64'd0, 32'd0);
      checkOutput("lat4_first_valid", {63'd0, c_valid}, 64'd1);
      checkOutput("lat4_first_inst", {32'd0, c_inst}, {32'd0, words[0]});
      inst_ena = 1'b0;
      #3 rst = 1'b0;
      #1;
      checkOutput("midrst_valid", {63'd0, c_valid}, 64'd0);
      checkOutput("midrst_inst", {32'd0, c_inst}, {32'd0, NOP});
      checkOutput("midrst_addr", c_resp, 64'd0);
      #2 rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 64'd0, 1'b0, 64'd0, 32'd0);
         checkOutput($sformatf("postrst_valid%0d", i), {63'd0, c_valid}, 64'd0);
      end
      applyStimulus(1'b1, 64'h8, 1'b0, 64'd0, 32'd0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 64'd0, 1'b0, 64'd0, 32'd0);
      checkOutput("postrst_resp_valid", {63'd0, c_valid}, 64'd1);
      checkOutput("postrst_resp_inst", {32'd0, c_inst}, {32'd0, words[2]});
      checkOutput("postrst_resp_addr", c_resp, 64'h8);

      // Non-zero base address
      d_inst_ena  = 1'b1;
      d_inst_addr = 64'h8000_0000;
      tick();
      checkOutput("base_valid", {63'd0, d_valid}, 64'd1);
      checkOutput("base_inst", {32'd0, d_inst}, {32'd0, 32'hABCD0001});
      checkOutput("base_fault", {63'd0, d_fault}, 64'd0);
      d_inst_addr = 64'h7FFF_FFFC;
      tick();
      checkOutput("below_base_fault", {63'd0, d_fault}, 64'd1);
      checkOutput("below_base_inst", {32'd0, d_inst}, {32'd0, NOP});
      checkOutput("below_base_addr", d_resp, 64'h7FFF_FFFC);
      d_inst_ena = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
